nand_page_read_verify: RTL
==========================

// Module: nand_page_read_verify
// PURPOSE
//  Read-back checker for the NAND multi-write test. Walks blocks INITIAL_BLOCK..LAST_BLOCK, pages 0..PAGE_PER_BLOCK.
//  Per page it issues 00h/5-addr/30h, waits on R/B#, then strobes out DATA_BYTES_PER_PAGE bytes via RE#.
//  Each byte is compared against a regenerated LFSR stream, and bit errors are counted per page and in total.
//  Sits beside the erase/program controller on the same NAND pins and 8-bit io bus.
// PARAMETERS
//  INITIAL_BLOCK        12'h000  first block read
//  LAST_BLOCK           2127     last block read (inclusive)
//  PAGE_PER_BLOCK       8'hFF    last page index per block (inclusive)
//  DATA_BYTES_PER_PAGE  8192     bytes compared per page, column 0 upward; spare area not read
//  RB_TIMEOUT           2**20    max clk cycles spent in one R/B# wait
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous reset, active-high
//  start        in   1   1-cycle pulse; begins a full scan when idle
//  rb           in   1   NAND ready/busy#, 1 = ready
//  io           inout 8  NAND data bus; driven only during command/address cycles, otherwise Z
//  cle,ale      out  1   NAND command/address latch enables
//  we,re,ce     out  1   NAND write/read/chip enables, active-low
//  busy         out  1   scan in progress
//  done         out  1   1-cycle pulse at scan end (normal or timeout)
//  page_valid   out  1   1-cycle pulse; page_errs/page_addr/block_addr valid
//  page_addr    out  8   page just checked
//  block_addr   out  12  block just checked
//  page_errs    out  17  bit errors in that page (max 65536)
//  total_errs   out  32  accumulated bit errors; saturates at 32'hFFFF_FFFF; cleared on start
//  timeout_err  out  1   sticky; set on R/B# timeout; cleared on start
// BEHAVIOUR
//  Reset/IDLE: ce=1, we=1, re=1, cle=0, ale=0, io=Z.
//   busy, done, page_valid and timeout_err are 0; counters are 0; FSM is in IDLE.
//  Reset during any state gives these values on the next cycle. A later start re-issues FFh first.
//  start while busy: ignored.
//  Cmd cycle, 4 clk: {cle=1,we=1,io=cmd} -> {we=0} -> {we=1} -> {cle=0}.
//   Address cycle: identical timing with ale in place of cle. ce=0 throughout the scan.
//  Read byte, 3 clk: re=0 -> re=0 (io sampled at the end of this cycle) -> re=1.
//  FSM:
//   IDLE -start-> RST_CMD(FFh) -> RST_WAIT (rb==1) -> RD_CMD0(00h)
//   RD_CMD0 -> RD_ADDR: 5 bytes 00,00,page,block[7:0],{4'b0,block[11:8]}
//   RD_ADDR -> RD_CMD1(30h) -> BUSY_WAIT
//   BUSY_WAIT: wait 4 clk (tWB), then rb==1 -> DATA_RD
//   DATA_RD: repeat DATA_BYTES_PER_PAGE reads -> PAGE_DONE
//   PAGE_DONE: pulse page_valid -> NEXT
//   NEXT: page<PAGE_PER_BLOCK -> page+1, RD_CMD0
//         else block<LAST_BLOCK -> page=0, block+1, RD_CMD0
//         else DONE
//   DONE: pulse done, ce=1 -> IDLE
//  Compare: errs += popcount(io_sample ^ expected). The LFSR advances exactly once per compared byte.
//   The LFSR is reseeded only at start, not per page, so it matches the programmer's continuous stream.
//  page_errs is cleared at RD_CMD0 of each page. total_errs is updated in the same cycle as page_errs.
//  Timeout: one counter per R/B# wait (RST_WAIT, BUSY_WAIT). On reaching RB_TIMEOUT: set timeout_err,
//   ce=1, go to DONE. No page_valid is issued for that page.
//  Address arithmetic: page is 8-bit and block is 12-bit; no wrap, because termination precedes overflow.
// STRUCTURE
//  Shared package (nand_pkg): command constants CMD_RESET=FFh, CMD_READ0=00h, CMD_READ1=30h,
//   CMD_STATUS=70h; FSM state enum; status-bit masks.
//  Sub-module nand_lfsr8: polynomial x^8+x^6+x^5+x^4+1, seed 8'hFF, inputs en and sync reset, 8-bit output.
//   The programmer instantiates the same sub-module.
//  The popcount (8-bit -> 4-bit) is a local function.
// TESTING (bench has a behavioural NAND model whose page data is the nand_lfsr8 stream)
//  1 Error-free page: 1 block, 1 page, DATA_BYTES=16.
//    -> page_errs=0, total_errs=0, done 1 cycle, timeout_err=0.
//  2 Model XORs byte3 with 8'h01 and byte10 with 8'hFF.
//    -> page_errs=9, total_errs=9.
//  3 Block 12'h84F, page 8'h12.
//    -> ALE bytes 00,00,12,4F,08; CLE bytes FF,00,30 in order.
//  4 PAGE_PER_BLOCK=1, two blocks.
//    -> 4 page_valid pulses at (0,0),(0,1),(1,0),(1,1); all page_errs=0, which proves LFSR continuity.
//  5 rb held low after 30h, RB_TIMEOUT=100.
//    -> timeout_err=1 within 100+4 clk, done pulse, ce=1, no page_valid.
//  6 rst asserted mid-DATA_RD.
//    -> next cycle: io=Z, ce=1, we=re=1, busy=0. A new start emits FFh first and yields correct counts.

Source files
------------

// File: rtl/nand_pkg.sv
// Shared NAND definitions for the multi-write test controllers.
// Contents:
//   - ONFI command opcodes used by the read-back checker and programmer
//   - status register bit masks (returned after CMD_STATUS)
//   - reference LFSR seed shared by generator and checker
//   - read-verify FSM state encoding
package nand_pkg;

  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_READ0  = 8'h00;
  localparam logic [7:0] CMD_READ1  = 8'h30;
  localparam logic [7:0] CMD_STATUS = 8'h70;

  localparam logic [7:0] STATUS_FAIL_MASK = 8'h01;
  localparam logic [7:0] STATUS_RDY_MASK  = 8'h40;
  localparam logic [7:0] STATUS_WPN_MASK  = 8'h80;

  localparam logic [7:0] LFSR_SEED = 8'hFF;

  // Minimum cycles between the 30h WE# edge and R/B# being meaningful (tWB).
  localparam int unsigned TWB_CYCLES = 4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RST_CMD,
    S_RST_WAIT,
    S_RD_CMD0,
    S_RD_ADDR,
    S_RD_CMD1,
    S_BUSY_WAIT,
    S_DATA_RD,
    S_PAGE_DONE,
    S_NEXT,
    S_DONE
  } rv_state_e;

endpackage

// File: rtl/nand_lfsr8.sv
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, seed 8'hFF.
// Shared by the page programmer and the read-back checker so both see the
// same continuous byte stream.
// Ports:
//   clk   in  system clock
//   rst   in  synchronous reseed (active-high), wins over en_i
//   en_i  in  advance the sequence by one step
//   q_o   out current 8-bit LFSR state (the stream byte)
module nand_lfsr8
  import nand_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  output logic [7:0] q_o
);

  logic [7:0] state_q;
  logic [7:0] state_d;

  // Taps 8,6,5,4 map to bits 7,5,4,3 of a left-shifting register.
  always_comb begin
    state_d = state_q;
    if (en_i) begin
      state_d = {state_q[6:0], state_q[7] ^ state_q[5] ^ state_q[4] ^ state_q[3]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LFSR_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign q_o = state_q;

endmodule

// File: rtl/nand_page_read_verify.sv
// Read-back checker for the NAND multi-write test.
// Walks blocks INITIAL_BLOCK..LAST_BLOCK and pages 0..PAGE_PER_BLOCK, issuing
// 00h/5 address/30h per page, waiting on R/B#, then strobing out
// DATA_BYTES_PER_PAGE bytes and comparing each to the regenerated LFSR stream.
// Ports:
//   clk, rst                sync active-high reset
//   start                   1-cycle pulse, starts a scan when idle
//   rb                      NAND ready/busy#, 1 = ready
//   io                      NAND bus, driven only during command/address cycles
//   cle, ale                command / address latch enables
//   we, re, ce              active-low strobes / chip enable
//   busy, done              scan in progress / 1-cycle end-of-scan pulse
//   page_valid              1-cycle pulse: page_addr/block_addr/page_errs valid
//   page_addr, block_addr   page just checked
//   page_errs               bit errors in that page
//   total_errs              saturating bit-error total, cleared on start
//   timeout_err             sticky R/B# timeout flag, cleared on start
module nand_page_read_verify
  import nand_pkg::*;
#(
  parameter logic [11:0] INITIAL_BLOCK       = 12'h000,
  parameter logic [11:0] LAST_BLOCK          = 12'd2127,
  parameter logic [7:0]  PAGE_PER_BLOCK      = 8'hFF,
  parameter int unsigned DATA_BYTES_PER_PAGE = 8192,
  parameter int unsigned RB_TIMEOUT          = 2**20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rb,
  inout  wire  [7:0]  io,
  output logic        cle,
  output logic        ale,
  output logic        we,
  output logic        re,
  output logic        ce,
  output logic        busy,
  output logic        done,
  output logic        page_valid,
  output logic [7:0]  page_addr,
  output logic [11:0] block_addr,
  output logic [16:0] page_errs,
  output logic [31:0] total_errs,
  output logic        timeout_err
);

  localparam int BYTE_W = $clog2(DATA_BYTES_PER_PAGE + 1);
  localparam int WAIT_W = $clog2(RB_TIMEOUT + 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(DATA_BYTES_PER_PAGE - 1);
  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(RB_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] TWB       = WAIT_W'(TWB_CYCLES);

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [3:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {29'd0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  rv_state_e         state_q, state_d;
  logic [1:0]        phase_q, phase_d;
  logic [2:0]        addr_idx_q, addr_idx_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [7:0]        page_q, page_d;
  logic [11:0]       block_q, block_d;
  logic [16:0]       page_errs_q, page_errs_d;
  logic [31:0]       total_q, total_d;
  logic              timeout_q, timeout_d;

  logic       io_oe;
  logic [7:0] io_out;
  logic [7:0] addr_byte;
  logic [7:0] lfsr_q;
  logic       lfsr_en;
  logic       lfsr_rst;
  logic [3:0] bit_errs;

  // Reseeded only when a scan starts: the programmer wrote one continuous stream.
  nand_lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst | lfsr_rst),
    .en_i (lfsr_en),
    .q_o  (lfsr_q)
  );

  assign io       = io_oe ? io_out : 8'hzz;
  assign bit_errs = popcount8(io ^ lfsr_q);

  always_comb begin
    case (addr_idx_q)
      3'd2:    addr_byte = page_q;
      3'd3:    addr_byte = block_q[7:0];
      3'd4:    addr_byte = {4'b0000, block_q[11:8]};
      default: addr_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    addr_idx_d  = addr_idx_q;
    byte_d      = byte_q;
    wait_d      = wait_q;
    page_d      = page_q;
    block_d     = block_q;
    page_errs_d = page_errs_q;
    total_d     = total_q;
    timeout_d   = timeout_q;
    cle         = 1'b0;
    ale         = 1'b0;
    we          = 1'b1;
    re          = 1'b1;
    ce          = 1'b1;
    io_oe       = 1'b0;
    io_out      = 8'h00;
    busy        = 1'b1;
    done        = 1'b0;
    page_valid  = 1'b0;
    lfsr_en     = 1'b0;
    lfsr_rst    = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d     = S_RST_CMD;
          phase_d     = '0;
          page_d      = '0;
          block_d     = INITIAL_BLOCK;
          page_errs_d = '0;
          total_d     = '0;
          timeout_d   = 1'b0;
          lfsr_rst    = 1'b1;
        end
      end

      // Command cycle: latch high for phases 0..2, WE# low in phase 1,
      // io held through phase 3 for hold time after the WE# rising edge.
      S_RST_CMD, S_RD_CMD0, S_RD_CMD1: begin
        ce      = 1'b0;
        io_oe   = 1'b1;
        cle     = (phase_q != 2'd3);
        we      = (phase_q != 2'd1);
        phase_d = phase_q + 2'd1;
        case (state_q)
          S_RST_CMD: io_out = CMD_RESET;
          S_RD_CMD0: io_out = CMD_READ0;
          default:   io_out = CMD_READ1;
        endcase
        if (state_q == S_RD_CMD0) begin
          page_errs_d = '0;
          byte_d      = '0;
          addr_idx_d  = '0;
        end
        if (phase_q == 2'd3) begin
          wait_d = '0;
          case (state_q)
            S_RST_CMD: state_d = S_RST_WAIT;
            S_RD_CMD0: state_d = S_RD_ADDR;
            default:   state_d = S_BUSY_WAIT;
          endcase
        end
      end

      S_RD_ADDR: begin
        ce      = 1'b0;
        io_oe   = 1'b1;
        io_out  = addr_byte;
        ale     = (phase_q != 2'd3);
        we      = (phase_q != 2'd1);
        phase_d = phase_q + 2'd1;
        if (phase_q == 2'd3) begin
          if (addr_idx_q == 3'd4) begin
            state_d = S_RD_CMD1;
          end else begin
            addr_idx_d = addr_idx_q + 3'd1;
          end
        end
      end

      // Timeout leaves ce high from the next cycle on (DONE deselects).
      S_RST_WAIT: begin
        ce = 1'b0;
        if (rb) begin
          state_d = S_RD_CMD0;
          phase_d = '0;
        end else if (wait_q == LAST_WAIT) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      // R/B# is ignored for the first tWB cycles after 30h.
      S_BUSY_WAIT: begin
        ce = 1'b0;
        if ((wait_q >= TWB) && rb) begin
          state_d = S_DATA_RD;
          phase_d = '0;
        end else if (wait_q == LAST_WAIT) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      // Byte read: RE# low in phases 0..1, io sampled at end of phase 1.
      S_DATA_RD: begin
        ce = 1'b0;
        re = (phase_q == 2'd2);
        case (phase_q)
          2'd0: phase_d = 2'd1;
          2'd1: begin
            phase_d     = 2'd2;
            lfsr_en     = 1'b1;
            page_errs_d = page_errs_q + {13'd0, bit_errs};
            total_d     = sat_add32(total_q, bit_errs);
          end
          default: begin
            phase_d = 2'd0;
            if (byte_q == LAST_BYTE) begin
              state_d = S_PAGE_DONE;
            end else begin
              byte_d = byte_q + BYTE_W'(1);
            end
          end
        endcase
      end

      S_PAGE_DONE: begin
        ce         = 1'b0;
        page_valid = 1'b1;
        state_d    = S_NEXT;
      end

      S_NEXT: begin
        ce      = 1'b0;
        phase_d = '0;
        if (page_q < PAGE_PER_BLOCK) begin
          page_d  = page_q + 8'd1;
          state_d = S_RD_CMD0;
        end else if (block_q < LAST_BLOCK) begin
          page_d  = '0;
          block_d = block_q + 12'd1;
          state_d = S_RD_CMD0;
        end else begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---- state / counter register stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      addr_idx_q  <= '0;
      byte_q      <= '0;
      wait_q      <= '0;
      page_q      <= '0;
      block_q     <= '0;
      page_errs_q <= '0;
      total_q     <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      addr_idx_q  <= addr_idx_d;
      byte_q      <= byte_d;
      wait_q      <= wait_d;
      page_q      <= page_d;
      block_q     <= block_d;
      page_errs_q <= page_errs_d;
      total_q     <= total_d;
      timeout_q   <= timeout_d;
    end
  end

  assign page_addr   = page_q;
  assign block_addr  = block_q;
  assign page_errs   = page_errs_q;
  assign total_errs  = total_q;
  assign timeout_err = timeout_q;

endmodule
